// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI round-robin arbiter.
// Combinational definitions only; no latency or flow control of its own.
// Imported by spi_arbiter and spi_rr_picker.
package spi_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin search: first set request at or above ptr_i, wrapping at NUM_REQ.
// Purely combinational, zero latency.
// No backpressure; valid_o simply reflects whether any request is set.
module spi_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI controller between NUM_REQ requesters; SPI_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: req sampled -> gnt/spi_start next cycle; spi_done -> rsp_valid next cycle.
// Backpressure: one transaction in flight; other requesters hold req until their gnt.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_din,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_dout,
    output logic                        rsp_err,
    output logic                        busy,
    output logic                        spi_start,
    output logic                        spi_wr,
    output logic [ADDR_W-1:0]           spi_addr,
    output logic [DATA_W-1:0]           spi_din,
    input  logic [DATA_W-1:0]           spi_dout,
    input  logic                        spi_done,
    input  logic                        spi_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("spi_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
    end

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_dout_q, rsp_dout_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q;
    logic                spi_start_q, spi_start_d;
    logic                spi_wr_q, spi_wr_d;
    logic [ADDR_W-1:0]   spi_addr_q, spi_addr_d;
    logic [DATA_W-1:0]   spi_din_q, spi_din_d;

    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic                tmo_hit;

    spi_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    assign owner_onehot = NUM_REQ'(1) << owner_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    // Cleared while in ISSUE so the count starts at zero on the first WAIT cycle.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_ISSUE) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_WAIT && !spi_done) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign tmo_hit = (state_q == ST_WAIT) && (wd_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        spi_start_d = 1'b0;
        rsp_valid_d = '0;
        rsp_dout_d  = rsp_dout_q;
        rsp_err_d   = rsp_err_q;
        spi_wr_d    = spi_wr_q;
        spi_addr_d  = spi_addr_q;
        spi_din_d   = spi_din_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d     = pick_idx;
                    spi_wr_d    = req_wr[pick_idx];
                    spi_addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    spi_din_d   = req_din[pick_idx*DATA_W +: DATA_W];
                    gnt_d       = NUM_REQ'(1) << pick_idx;
                    spi_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the timeout cycle takes priority over the watchdog.
                if (spi_done) begin
                    rsp_valid_d = owner_onehot;
                    rsp_dout_d  = spi_wr_q ? '0 : spi_dout;
                    rsp_err_d   = spi_err;
                    state_d     = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_valid_d = owner_onehot;
                    rsp_dout_d  = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_dout_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            spi_start_q <= 1'b0;
            spi_wr_q    <= 1'b0;
            spi_addr_q  <= '0;
            spi_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dout_q  <= rsp_dout_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= (state_d != ST_IDLE);
            spi_start_q <= spi_start_d;
            spi_wr_q    <= spi_wr_d;
            spi_addr_q  <= spi_addr_d;
            spi_din_q   <= spi_din_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dout  = rsp_dout_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign spi_start = spi_start_q;
    assign spi_wr    = spi_wr_q;
    assign spi_addr  = spi_addr_q;
    assign spi_din   = spi_din_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: predicted grants/responses queued at stimulus time,
// popped by a negedge monitor; an SPI controller model replays per-transaction plans.
module tb_spi_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req, req_wr;
    logic [N*8-1:0]   req_addr, req_din;
    logic [N-1:0]     gnt, rsp_valid;
    logic [7:0]       rsp_dout;
    logic             rsp_err, busy, spi_start, spi_wr;
    logic [7:0]       spi_addr, spi_din, spi_dout;
    logic             spi_done, spi_err;

    spi_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_din(req_din), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
        .rsp_err(rsp_err), .busy(busy), .spi_start(spi_start), .spi_wr(spi_wr),
        .spi_addr(spi_addr), .spi_din(spi_din), .spi_dout(spi_dout),
        .spi_done(spi_done), .spi_err(spi_err)
    );

    always #5 clk = ~clk;

    typedef struct { int owner; logic wr; logic [7:0] addr; logic [7:0] din; } gexp_t;
    typedef struct { int owner; logic [7:0] dout; logic err; bit tmo; } rexp_t;
    typedef struct { int lat; logic [7:0] dout; logic err; } plan_t;

    gexp_t gq[$];
    rexp_t rq[$];
    plan_t pq[$];
    plan_t dir_plans[$];

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int spi_gen = 0;
    int spur_cnt = 0;
    int unsigned cyc = 0;

    logic       op_wr   [N];
    logic [7:0] op_addr [N];
    logic [7:0] op_din  [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {gnt, rsp_valid, rsp_dout, rsp_err, busy, spi_start, spi_wr, spi_addr, spi_din};
    endfunction

    // Round-robin rule: first pending requester at or after p, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic wr, input logic [7:0] addr, input logic [7:0] din);
        op_wr[i] = wr; op_addr[i] = addr; op_din[i] = din;
    endtask

    // reps == 0: each requester drops after its gnt; reps > 0: mask held for reps grants.
    task automatic run_batch(input logic [N-1:0] mask, input int reps, input bit early_exit);
        logic [N-1:0] m, d;
        int p, o, n_exp, n_got, budget;
        plan_t pl;
        m = mask; p = model_ptr; n_exp = 0;
        while (m != '0 && (reps == 0 || n_exp < reps)) begin
            o = pick(m, p);
            gq.push_back('{o, op_wr[o], op_addr[o], op_din[o]});
            if (dir_plans.size() > 0) pl = dir_plans.pop_front();
            else pl = '{$urandom_range(1, 6), 8'($urandom), ($urandom_range(0, 7) == 0)};
            pq.push_back(pl);
            if (pl.lat >= 0) begin
                rq.push_back('{o, op_wr[o] ? 8'h00 : pl.dout, pl.err, 1'b0});
                p = (o + 1) % N;
            end else begin
`ifdef SPI_ARB_TIMEOUT_EN
                rq.push_back('{o, 8'h00, 1'b1, 1'b1});
                p = (o + 1) % N;
`endif
            end
            if (reps == 0) m[o] = 1'b0;
            n_exp++;
        end
        model_ptr = p;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                req_wr[i] = op_wr[i];
                req_addr[8*i +: 8] = op_addr[i];
                req_din[8*i +: 8]  = op_din[i];
            end
        end
        req = req | mask;
        n_got = 0; budget = 0;
        forever begin
            @(negedge clk);
            if (budget == 0) chk("gnt_latency", (gnt != '0), 1);
            d = '0;
            if ((gnt & mask) != '0) begin
                n_got++;
                if (reps == 0) d = gnt & mask;
                else if (n_got == reps) d = mask;
            end
            @(posedge clk);
            #1 req = req & ~d;
            budget++;
            if (n_got >= n_exp && (early_exit || (gq.size() == 0 && rq.size() == 0))) break;
            if (budget > 3000) begin
                chk("batch_cycle_budget", budget, 0);
                break;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents gnt or rsp_valid.
    gexp_t       cur;
    bit          in_txn = 1'b0;
    int unsigned start_cyc = 0;
    always @(negedge clk) begin : monitor
        gexp_t g;
        rexp_t r;
        if (!rst) begin
            in_txn = 1'b0;
        end else begin
            if (gnt != '0) begin
                if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
                else begin
                    g = gq.pop_front();
                    chk("gnt_owner", gnt, 64'd1 << g.owner);
                    chk("spi_start_with_gnt", spi_start, 1);
                    chk("spi_operands", {spi_wr, spi_addr, spi_din}, {g.wr, g.addr, g.din});
                    cur = g; in_txn = 1'b1; start_cyc = cyc;
                end
            end else if (spi_start) begin
                chk("spi_start_without_gnt", spi_start, 0);
            end
            if (in_txn && spi_done)
                chk("spi_operands_held", {spi_wr, spi_addr, spi_din}, {cur.wr, cur.addr, cur.din});
            if (rsp_valid != '0) begin
                if (rq.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
                else begin
                    r = rq.pop_front();
                    chk("rsp_valid_owner", rsp_valid, 64'd1 << r.owner);
                    chk("rsp_dout", rsp_dout, r.dout);
                    chk("rsp_err", rsp_err, r.err);
                    chk("busy_in_resp", busy, 1);
                    if (r.tmo) chk("timeout_cycles", cyc - start_cyc, TO + 1);
                end
                in_txn = 1'b0;
            end
        end
    end

    // SPI controller model: each spi_start consumes the next queued plan.
    initial begin : spi_model
        plan_t p;
        int    g;
        int    spur_seen;
        spur_seen = 0; spi_done = 1'b0; spi_err = 1'b0; spi_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (spur_cnt != spur_seen) begin
                spur_seen = spur_cnt;
                spi_done = 1'b1; spi_err = 1'b1; spi_dout = 8'hFF;
                @(negedge clk);
                spi_done = 1'b0; spi_err = 1'b0;
            end else if (rst && spi_start) begin
                chk("spi_start_planned", (pq.size() != 0), 1);
                if (pq.size() != 0) begin
                    p = pq.pop_front();
                    g = spi_gen;
                    if (p.lat >= 0) begin
                        repeat (p.lat) @(negedge clk);
                        if (g == spi_gen) begin
                            spi_done = 1'b1; spi_dout = p.dout; spi_err = p.err;
                            @(negedge clk);
                            spi_done = 1'b0; spi_err = 1'b0; spi_dout = 8'($urandom);
                            if (g == spi_gen) chk("rsp_latency", (rsp_valid != '0), 1);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: run did not complete, %0d errors so far", errors);
        $fatal(1, "global timeout");
    end

    initial begin : stim
        logic [N-1:0] mk;
        int           reps;
        rst = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_din = '0;
        for (int i = 0; i < N; i++) set_op(i, 1'b0, 8'h00, 8'h00);
        #12;
        chk("reset_outputs", outs_vec(), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < N; i++) set_op(i, i[0], 8'(8'h10 + i), 8'(8'hC0 + i));
        run_batch(4'b1111, 0, 1'b0);
        run_batch(4'b0101, 4, 1'b0);

        set_op(0, 1'b1, 8'h05, 8'hA5);
        dir_plans.push_back('{3, 8'h3C, 1'b0});
        run_batch(4'b0001, 0, 1'b0);
        set_op(1, 1'b0, 8'h05, 8'h00);
        dir_plans.push_back('{2, 8'hA5, 1'b0});
        run_batch(4'b0010, 0, 1'b0);

        set_op(2, 1'b0, 8'h40, 8'h00);
        dir_plans.push_back('{1, 8'h5A, 1'b1});
        run_batch(4'b0100, 0, 1'b0);
        set_op(3, 1'b0, 8'h41, 8'h00);
        dir_plans.push_back('{4, 8'h77, 1'b0});
        run_batch(4'b1000, 0, 1'b0);

        spur_cnt++;
        repeat (4) @(negedge clk);
        chk("idle_after_stray_done", busy, 0);

        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < N; i++) set_op(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            mk   = N'($urandom_range(1, (1 << N) - 1));
            reps = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 0;
            run_batch(mk, reps, 1'b0);
        end

        set_op(3, 1'b0, 8'h66, 8'h00);
        dir_plans.push_back('{-1, 8'h00, 1'b0});
`ifdef SPI_ARB_TIMEOUT_EN
        run_batch(4'b1000, 0, 1'b0);
        dir_plans.push_back('{-1, 8'h00, 1'b0});
        run_batch(4'b1000, 0, 1'b1);
`else
        run_batch(4'b1000, 0, 1'b1);
        repeat (40) @(negedge clk);
        chk("busy_without_done", busy, 1);
`endif

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", outs_vec(), 0);
        gq.delete(); rq.delete(); pq.delete();
        spi_gen++; model_ptr = 0; req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        set_op(1, 1'b0, 8'h21, 8'h00);
        set_op(3, 1'b1, 8'h23, 8'h99);
        run_batch(4'b1010, 0, 1'b0);

        repeat (10) @(negedge clk);
        chk("grant_queue_drained", gq.size(), 0);
        chk("rsp_queue_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
